// File: rtl/vc_link_buffer.sv
// Per-VC flit input buffer: first-word fall-through FIFO per virtual channel, one flit out
// per cycle via fixed-priority or round-robin arbitration, optional wormhole lock HEAD..TAIL.
module vc_link_buffer #(
  parameter  int FLIT_WIDTH = 34,
  parameter  int N_VIRT_CHN = 3,
  parameter  int BUFF_DEPTH = 4,
  parameter  int ARB_MODE   = 0,
  parameter  int LOCK_PKT   = 1,
  localparam int VC_W       = (N_VIRT_CHN > 1) ? $clog2(N_VIRT_CHN) : 1
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  in_valid,
  input  logic [VC_W-1:0]       in_vc_id,
  input  logic [FLIT_WIDTH-1:0] in_fdata,
  output logic [N_VIRT_CHN-1:0] in_ready,
  output logic                  out_valid,
  output logic [VC_W-1:0]       out_vc_id,
  output logic [FLIT_WIDTH-1:0] out_fdata,
  input  logic [N_VIRT_CHN-1:0] out_ready,
  output logic                  lock_active
);

  localparam int PTR_W = $clog2(BUFF_DEPTH);
  localparam int CNT_W = $clog2(BUFF_DEPTH + 1);
  localparam logic [1:0] FT_HEAD = 2'b00;
  localparam logic [1:0] FT_TAIL = 2'b10;

  typedef enum logic {ST_UNLOCKED, ST_LOCKED} lock_state_t;

  logic [FLIT_WIDTH-1:0] mem_q    [N_VIRT_CHN][BUFF_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q [N_VIRT_CHN];
  logic [PTR_W-1:0]      wr_ptr_d [N_VIRT_CHN];
  logic [PTR_W-1:0]      rd_ptr_q [N_VIRT_CHN];
  logic [PTR_W-1:0]      rd_ptr_d [N_VIRT_CHN];
  logic [CNT_W-1:0]      cnt_q    [N_VIRT_CHN];
  logic [CNT_W-1:0]      cnt_d    [N_VIRT_CHN];
  logic [FLIT_WIDTH-1:0] head     [N_VIRT_CHN];

  logic [N_VIRT_CHN-1:0] push;
  logic [N_VIRT_CHN-1:0] pop;
  logic [N_VIRT_CHN-1:0] eligible;
  logic [VC_W-1:0]       grant;
  logic                  rr_found;
  logic [VC_W-1:0]       rr_ptr_q;
  logic [VC_W-1:0]       rr_ptr_d;
  logic [VC_W-1:0]       lock_vc_q;
  logic                  lock_active_q;
  lock_state_t           state_q;
  logic [1:0]            out_type;

  always_comb begin
    for (int v = 0; v < N_VIRT_CHN; v++) begin
      in_ready[v] = (cnt_q[v] != CNT_W'(BUFF_DEPTH));
      push[v]     = in_valid && (in_vc_id == VC_W'(v)) && in_ready[v];
      head[v]     = mem_q[v][rd_ptr_q[v]];
      // While a packet is locked only its own VC may compete.
      eligible[v] = (cnt_q[v] != '0) && out_ready[v] &&
                    ((state_q == ST_UNLOCKED) || (lock_vc_q == VC_W'(v)));
    end
  end

  always_comb begin
    grant    = '0;
    rr_found = 1'b0;
    if (ARB_MODE == 0) begin
      for (int v = 0; v < N_VIRT_CHN; v++)
        if (eligible[v]) grant = VC_W'(v);
    end else begin
      // Downward scans leave the lowest match: first at/after rr_ptr, else first overall.
      for (int v = N_VIRT_CHN - 1; v >= 0; v--)
        if (eligible[v] && (VC_W'(v) >= rr_ptr_q)) begin
          grant    = VC_W'(v);
          rr_found = 1'b1;
        end
      if (!rr_found)
        for (int v = N_VIRT_CHN - 1; v >= 0; v--)
          if (eligible[v]) grant = VC_W'(v);
    end
  end

  always_comb begin
    out_valid = |eligible;
    out_vc_id = out_valid ? grant : '0;
    out_fdata = '0;
    for (int v = 0; v < N_VIRT_CHN; v++) begin
      pop[v] = out_valid && (grant == VC_W'(v));
      if (pop[v]) out_fdata = head[v];
    end
    out_type = out_fdata[FLIT_WIDTH-1 -: 2];
  end

  always_comb begin
    for (int v = 0; v < N_VIRT_CHN; v++) begin
      wr_ptr_d[v] = push[v] ? wr_ptr_q[v] + PTR_W'(1) : wr_ptr_q[v];
      rd_ptr_d[v] = pop[v]  ? rd_ptr_q[v] + PTR_W'(1) : rd_ptr_q[v];
      cnt_d[v]    = cnt_q[v] + CNT_W'(push[v]) - CNT_W'(pop[v]);
    end
    rr_ptr_d = rr_ptr_q;
    if (out_valid && (state_q == ST_UNLOCKED))
      rr_ptr_d = (grant == VC_W'(N_VIRT_CHN - 1)) ? '0 : grant + VC_W'(1);
  end

  always_ff @(posedge clk) begin
    for (int v = 0; v < N_VIRT_CHN; v++)
      if (push[v]) mem_q[v][wr_ptr_q[v]] <= in_fdata;
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      for (int v = 0; v < N_VIRT_CHN; v++) begin
        wr_ptr_q[v] <= '0;
        rd_ptr_q[v] <= '0;
        cnt_q[v]    <= '0;
      end
      rr_ptr_q <= '0;
    end else begin
      for (int v = 0; v < N_VIRT_CHN; v++) begin
        wr_ptr_q[v] <= wr_ptr_d[v];
        rd_ptr_q[v] <= rd_ptr_d[v];
        cnt_q[v]    <= cnt_d[v];
      end
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state_q       <= ST_UNLOCKED;
      lock_vc_q     <= '0;
      lock_active_q <= 1'b0;
    end else if ((LOCK_PKT != 0) && out_valid) begin
      case (state_q)
        ST_UNLOCKED:
          if (out_type == FT_HEAD) begin
            state_q       <= ST_LOCKED;
            lock_vc_q     <= grant;
            lock_active_q <= 1'b1;
          end
        ST_LOCKED:
          if (out_type == FT_TAIL) begin
            state_q       <= ST_UNLOCKED;
            lock_active_q <= 1'b0;
          end
        default: begin
          state_q       <= ST_UNLOCKED;
          lock_active_q <= 1'b0;
        end
      endcase
    end
  end

  assign lock_active = lock_active_q;

endmodule

// File: tb/tb_vc_link_buffer.sv
// Bench for vc_link_buffer: fixed-priority/locking and round-robin/unlocked instances share
// stimulus; each is checked every cycle against a queue-based model plus directed checks.
module tb_vc_link_buffer;
  localparam int FW    = 34;
  localparam int N     = 3;
  localparam int DEPTH = 4;
  localparam logic [1:0] T_HEAD = 2'b00;
  localparam logic [1:0] T_BODY = 2'b01;
  localparam logic [1:0] T_TAIL = 2'b10;
  localparam logic [1:0] T_HT   = 2'b11;

  logic          clk = 1'b0;
  logic          arst;
  logic          in_valid;
  logic [1:0]    in_vc_id;
  logic [FW-1:0] in_fdata;
  logic [N-1:0]  out_ready;
  logic [N-1:0]  in_ready0, in_ready1;
  logic          out_valid0, out_valid1;
  logic [1:0]    out_vc_id0, out_vc_id1;
  logic [FW-1:0] out_fdata0, out_fdata1;
  logic          lock_active0, lock_active1;

  always #5 clk = ~clk;

  vc_link_buffer #(.FLIT_WIDTH(FW), .N_VIRT_CHN(N), .BUFF_DEPTH(DEPTH), .ARB_MODE(0), .LOCK_PKT(1)) dut0 (
    .clk(clk), .arst(arst), .in_valid(in_valid), .in_vc_id(in_vc_id), .in_fdata(in_fdata),
    .in_ready(in_ready0), .out_valid(out_valid0), .out_vc_id(out_vc_id0), .out_fdata(out_fdata0),
    .out_ready(out_ready), .lock_active(lock_active0));

  vc_link_buffer #(.FLIT_WIDTH(FW), .N_VIRT_CHN(N), .BUFF_DEPTH(DEPTH), .ARB_MODE(1), .LOCK_PKT(0)) dut1 (
    .clk(clk), .arst(arst), .in_valid(in_valid), .in_vc_id(in_vc_id), .in_fdata(in_fdata),
    .in_ready(in_ready1), .out_valid(out_valid1), .out_vc_id(out_vc_id1), .out_fdata(out_fdata1),
    .out_ready(out_ready), .lock_active(lock_active1));

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: instance 0 = fixed priority with lock, instance 1 = round-robin without lock.
  logic [FW-1:0] mq [2][N][$];
  bit            mlock [2];
  int            mlvc  [2];
  int            mrr   [2];

  function automatic logic [FW-1:0] mk(input logic [1:0] t, input logic [31:0] p);
    return {t, p};
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      for (int v = 0; v < N; v++) mq[d][v].delete();
      mlock[d] = 1'b0;
      mlvc[d]  = 0;
      mrr[d]   = 0;
    end
  endtask

  task automatic model_step(input int d);
    bit            elig [N];
    bit            ev;
    int            g;
    logic [FW-1:0] fd;
    logic [N-1:0]  ir;
    bit            do_push;
    bit            was_locked;
    logic [1:0]    ft;
    logic          ov, ola;
    logic [1:0]    ovc;
    logic [FW-1:0] ofd;
    logic [N-1:0]  oir;
    if (d == 0) begin
      ov = out_valid0; ovc = out_vc_id0; ofd = out_fdata0; ola = lock_active0; oir = in_ready0;
    end else begin
      ov = out_valid1; ovc = out_vc_id1; ofd = out_fdata1; ola = lock_active1; oir = in_ready1;
    end
    ev = 1'b0;
    g  = 0;
    for (int v = 0; v < N; v++)
      elig[v] = (mq[d][v].size() > 0) && out_ready[v] && (!mlock[d] || mlvc[d] == v);
    if (d == 0) begin
      for (int v = 0; v < N; v++)
        if (elig[v]) begin g = v; ev = 1'b1; end
    end else begin
      for (int k = 0; k < N; k++) begin
        int v;
        v = (mrr[d] + k) % N;
        if (!ev && elig[v]) begin g = v; ev = 1'b1; end
      end
    end
    fd = ev ? mq[d][g][0] : '0;
    for (int v = 0; v < N; v++) ir[v] = (mq[d][v].size() < DEPTH);

    chk($sformatf("d%0d_out_valid", d), 64'(ov), 64'(ev));
    chk($sformatf("d%0d_out_vc_id", d), 64'(ovc), 64'(ev ? g : 0));
    chk($sformatf("d%0d_out_fdata", d), 64'(ofd), 64'(fd));
    chk($sformatf("d%0d_lock_active", d), 64'(ola), 64'(mlock[d]));
    chk($sformatf("d%0d_in_ready", d), 64'(oir), 64'(ir));

    do_push = 1'b0;
    if (in_valid && int'(in_vc_id) < N) do_push = (mq[d][in_vc_id].size() < DEPTH);
    was_locked = mlock[d];
    if (ev) begin
      ft = fd[FW-1 -: 2];
      void'(mq[d][g].pop_front());
      if (d == 0) begin
        if (!mlock[d] && ft == T_HEAD) begin
          mlock[d] = 1'b1;
          mlvc[d]  = g;
        end else if (mlock[d] && ft == T_TAIL) begin
          mlock[d] = 1'b0;
        end
      end
      if (!was_locked) mrr[d] = (g + 1) % N;
    end
    if (do_push) mq[d][in_vc_id].push_back(in_fdata);
  endtask

  task automatic cyc(input logic iv, input int vc, input logic [FW-1:0] dat, input logic [N-1:0] ordy);
    @(negedge clk);
    in_valid  = iv;
    in_vc_id  = 2'(vc);
    in_fdata  = dat;
    out_ready = ordy;
    #1;
    model_step(0);
    model_step(1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, 64'(out_valid0), 64'd0);
    chk({tag, "_vc"}, 64'(out_vc_id0), 64'd0);
    chk({tag, "_data"}, 64'(out_fdata0), 64'd0);
    chk({tag, "_lock"}, 64'(lock_active0), 64'd0);
    chk({tag, "_ready"}, 64'(in_ready0), 64'h7);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = '1;
    arst      = 1'b0;
    #1;
    model_clear();
    model_step(0);
    model_step(1);
    @(negedge clk);
    arst = 1'b1;
  endtask

  initial begin
    logic [N-1:0] ordy;
    int           thr;
    arst = 1'b0; in_valid = 1'b0; in_vc_id = '0; in_fdata = '0; out_ready = '1;
    model_clear();
    #1;
    check_reset_outputs("rst0");
    apply_reset();

    // Single HEAD_TAIL on VC1
    cyc(1'b1, 1, 34'h3_0000_00AA, '1);
    cyc(1'b0, 0, '0, '1);
    chk("t1_valid", 64'(out_valid0), 64'd1);
    chk("t1_vc", 64'(out_vc_id0), 64'd1);
    chk("t1_data", 64'(out_fdata0), 64'h3_0000_00AA);
    cyc(1'b0, 0, '0, '1);
    chk("t1_empty", 64'(out_valid0), 64'd0);
    chk("t1_nolock", 64'(lock_active0), 64'd0);

    // Fill VC0 while blocked, offer a fifth, then drain
    for (int i = 0; i < 4; i++) cyc(1'b1, 0, mk(T_BODY, 32'h100 + 32'(i)), 3'b000);
    cyc(1'b1, 0, mk(T_BODY, 32'hDEAD), 3'b000);
    chk("t2_full", 64'(in_ready0[0]), 64'd0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 0, '0, 3'b001);
      chk("t2_drain", 64'(out_fdata0), 64'(mk(T_BODY, 32'h100 + 32'(i))));
      if (i == 1) chk("t2_ready_back", 64'(in_ready0[0]), 64'd1);
    end
    cyc(1'b0, 0, '0, 3'b001);
    chk("t2_drained", 64'(out_valid0), 64'd0);

    // Fixed priority order
    for (int v = 0; v < N; v++) cyc(1'b1, v, mk(T_HT, 32'h200 + 32'(v)), 3'b000);
    for (int k = 0; k < N; k++) begin
      cyc(1'b0, 0, '0, '1);
      chk("t3_prio_vc", 64'(out_vc_id0), 64'(2 - k));
    end

    // Round-robin order from rr_ptr = 0
    apply_reset();
    for (int i = 0; i < 6; i++) cyc(1'b1, i % N, mk(T_HT, 32'h300 + 32'(i)), 3'b000);
    for (int k = 0; k < 6; k++) begin
      cyc(1'b0, 0, '0, '1);
      chk("t4_rr_vc", 64'(out_vc_id1), 64'(k % N));
    end

    // Wormhole lock with late TAIL
    apply_reset();
    cyc(1'b1, 0, mk(T_HEAD, 32'h400), '1);
    cyc(1'b1, 0, mk(T_BODY, 32'h401), '1);
    cyc(1'b1, 2, mk(T_HT, 32'h402), '1);
    for (int j = 0; j < 3; j++) begin
      cyc(j == 2, 0, mk(T_TAIL, 32'h403), '1);
      chk("t5_stall_valid", 64'(out_valid0), 64'd0);
      chk("t5_stall_lock", 64'(lock_active0), 64'd1);
    end
    cyc(1'b0, 0, '0, '1);
    chk("t5_tail", 64'(out_fdata0), 64'(mk(T_TAIL, 32'h403)));
    cyc(1'b0, 0, '0, '1);
    chk("t5_vc2_sent", 64'(out_vc_id0), 64'd2);
    chk("t5_unlocked", 64'(lock_active0), 64'd0);

    // Reset mid-packet with lock held and 3 flits buffered
    cyc(1'b1, 0, mk(T_HEAD, 32'h500), '1);
    cyc(1'b1, 1, mk(T_HT, 32'h501), '1);
    cyc(1'b1, 0, mk(T_BODY, 32'h502), 3'b000);
    cyc(1'b1, 2, mk(T_HT, 32'h503), 3'b000);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = '1;
    #1;
    chk("t6_pre_lock", 64'(lock_active0), 64'd1);
    #1;
    arst = 1'b0;
    #1;
    check_reset_outputs("t6_rst");
    model_clear();
    model_step(0);
    model_step(1);
    @(negedge clk);
    arst = 1'b1;

    // Randomized traffic, alternating high and low downstream readiness
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) apply_reset();
      thr = ((i / 150) % 2 == 1) ? 3 : 9;
      for (int v = 0; v < N; v++) ordy[v] = ($urandom_range(0, 9) < thr);
      cyc($urandom_range(0, 9) < 7,
          ($urandom_range(0, 7) == 0) ? 3 : int'($urandom_range(0, N - 1)),
          mk(2'($urandom_range(0, 3)), $urandom()),
          ordy);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
